// File: rtl/systolic_pkg.sv
// Shared defaults, FSM encoding and wavefront lane-select helper for the skew feeder.
package systolic_pkg;

  localparam int DEF_LANES = 4;
  localparam int DEF_DW    = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_e;

  // Buffer row that feeds `lane` on beat `s`, or -1 where the wavefront is zero-padded.
  function automatic int lane_row(int s, int lane, int lanes, int depth);
    int r;
    r = s - (lanes - 1 - lane);
    return ((r >= 0) && (r < depth)) ? r : -1;
  endfunction

endpackage

// File: rtl/skew_lane_mux.sv
// One output lane: selects this lane's element of the row due on the current beat, else zero.
// Purely combinational; no handshake of its own.
module skew_lane_mux
  import systolic_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LANE  = 0,
  parameter int SCW   = 3
) (
  input  logic [SCW-1:0]           s_cnt,
  input  logic [DEPTH-1:0][DW-1:0] col,
  output logic [DW-1:0]            dat
);

  int row;

  always_comb begin
    row = lane_row(int'(s_cnt), LANE, LANES, DEPTH);
    dat = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (row == r) dat = col[r];
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Buffers a DEPTH-row tile, then streams it with per-lane diagonal skew to the systolic array.
// Latency: first beat one cycle after the tile completes; tile_done one cycle after the last beat.
// Backpressure: in_ready drops while streaming; hold freezes the stream. FEEDER_PINGPONG_EN adds a second tile buffer.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_data,
  input  logic                hold,
  output logic [LANES*DW-1:0] out_data,
  output logic                out_valid,
  output logic                tile_done,
  output logic                busy
);

  localparam int WCW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SCW = (DEPTH + LANES - 1 > 1) ? $clog2(DEPTH + LANES - 1) : 1;

  typedef logic [LANES-1:0][DW-1:0] row_t;
  typedef row_t [DEPTH-1:0]         tile_t;

  state_e         state_q, state_d;
  logic [WCW-1:0] wr_cnt_q, wr_cnt_d;
  logic [SCW-1:0] s_cnt_q, s_cnt_d;
  row_t           out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           tile_done_q, tile_done_d;
  logic           wr_fire, wr_last, s_last;
  tile_t          rd_tile;
  row_t           skew_dat;

`ifdef FEEDER_PINGPONG_EN
  logic       wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [1:0] full_q, full_d;
  tile_t      buf_q [2];
  tile_t      buf_d [2];
  assign rd_tile = buf_q[rd_sel_q];
`else
  tile_t      buf_q, buf_d;
  assign rd_tile = buf_q;
`endif

  assign wr_fire = in_valid && in_ready;
  assign wr_last = wr_fire && (wr_cnt_q == WCW'(DEPTH - 1));
  assign s_last  = (s_cnt_q == SCW'(DEPTH + LANES - 2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (wr_fire) state_d = wr_last ? STREAM : LOAD;
      LOAD:   if (wr_last) state_d = STREAM;
      STREAM: if (!hold && s_last) state_d = DONE;
      DONE: begin
`ifdef FEEDER_PINGPONG_EN
        // A tile already waiting in the other buffer streams back-to-back.
        if (full_q[~rd_sel_q] || wr_last)     state_d = STREAM;
        else if (wr_fire || wr_cnt_q != '0)   state_d = LOAD;
        else                                  state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
`ifdef FEEDER_PINGPONG_EN
    in_ready = !full_q[wr_sel_q];
    busy     = (wr_cnt_q != '0) || (|full_q);
`else
    in_ready = (state_q == IDLE) || (state_q == LOAD);
    busy     = (state_q == LOAD) || (state_q == STREAM);
`endif
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (wr_fire) wr_cnt_d = wr_last ? '0 : wr_cnt_q + 1'b1;

    buf_d = buf_q;
`ifdef FEEDER_PINGPONG_EN
    if (wr_fire) buf_d[wr_sel_q][wr_cnt_q] = in_data;
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    if (wr_last) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end
    if (state_q == DONE) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
`else
    if (wr_fire) buf_d[wr_cnt_q] = in_data;
`endif

    s_cnt_d     = s_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    tile_done_d = 1'b0;
    if (state_q == STREAM && !hold) begin
      out_data_d  = skew_dat;
      out_valid_d = 1'b1;
      s_cnt_d     = s_last ? '0 : s_cnt_q + 1'b1;
    end else if (state_q == DONE) begin
      out_data_d  = '0;
      out_valid_d = 1'b0;
      tile_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt_q    <= '0;
      s_cnt_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      tile_done_q <= 1'b0;
`ifdef FEEDER_PINGPONG_EN
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      full_q      <= '0;
`endif
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      s_cnt_q     <= s_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      tile_done_q <= tile_done_d;
`ifdef FEEDER_PINGPONG_EN
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      full_q      <= full_d;
`endif
    end
  end

  // Tile storage carries no reset; contents are only read after a full load.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DEPTH-1:0][DW-1:0] col;
    always_comb begin
      for (int r = 0; r < DEPTH; r++) col[r] = rd_tile[r][i];
    end
    skew_lane_mux #(
      .LANES(LANES), .DW(DW), .DEPTH(DEPTH), .LANE(i), .SCW(SCW)
    ) u_mux (
      .s_cnt (s_cnt_q),
      .col   (col),
      .dat   (skew_dat[i])
    );
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign tile_done = tile_done_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: hand-computed skew tables checked beat by beat.
`timescale 1ns/1ps
module tb_systolic_skew_feeder;

  typedef logic [31:0] tile_t  [4];
  typedef logic [31:0] beats_t [7];

  localparam tile_t  TA = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
  localparam beats_t BA = '{32'h01000000, 32'h05020000, 32'h09060300, 32'h0D0A0704,
                            32'h000E0B08, 32'h00000F0C, 32'h00000010};
  localparam tile_t  TB = '{32'h11121314, 32'h15161718, 32'h191A1B1C, 32'h1D1E1F20};
  localparam beats_t BB = '{32'h11000000, 32'h15120000, 32'h19161300, 32'h1D1A1714,
                            32'h001E1B18, 32'h00001F1C, 32'h00000020};

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        hold;
  logic [31:0] out_data;
  logic        out_valid;
  logic        tile_done;
  logic        busy;

  int n_chk;
  int n_fail;

  systolic_skew_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .hold      (hold),
    .out_data  (out_data),
    .out_valid (out_valid),
    .tile_done (tile_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tile(input tile_t t, input bit gaps);
    int n;
    for (int k = 0; k < 4; k++) begin
      if (gaps && k > 0) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_data  = t[k];
      n = 0;
      while (!in_ready && n < 100) begin
        step();
        n++;
      end
      chk("in_ready before transfer", 32'(in_ready), 32'd1);
      step();
      chk("busy after transfer", 32'(busy), 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic stream_check(input beats_t e, input int hold_after, input int hold_n, input string tag);
    chk({tag, " no beat on entry"}, 32'(out_valid), 32'd0);
    for (int b = 0; b < 7; b++) begin
      step();
      chk({tag, " beat data"}, out_data, e[b]);
      chk({tag, " beat valid"}, 32'(out_valid), 32'd1);
      chk({tag, " no early done"}, 32'(tile_done), 32'd0);
`ifndef FEEDER_PINGPONG_EN
      chk({tag, " in_ready low while streaming"}, 32'(in_ready), 32'd0);
`endif
      if (b == hold_after) begin
        hold = 1'b1;
        for (int h = 0; h < hold_n; h++) begin
          step();
          chk({tag, " held data"}, out_data, e[b]);
          chk({tag, " held valid"}, 32'(out_valid), 32'd1);
        end
        hold = 1'b0;
      end
    end
    step();
    chk({tag, " tile_done"}, 32'(tile_done), 32'd1);
    chk({tag, " valid after tile"}, 32'(out_valid), 32'd0);
    chk({tag, " data after tile"}, out_data, 32'd0);
`ifndef FEEDER_PINGPONG_EN
    chk({tag, " in_ready back in idle"}, 32'(in_ready), 32'd1);
    chk({tag, " busy back in idle"}, 32'(busy), 32'd0);
`endif
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    hold     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_data", out_data, 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset tile_done", 32'(tile_done), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    reset = 1'b1;
    step();

    load_tile(TA, 1'b0);
    stream_check(BA, -1, 0, "basic");
    step();
    chk("tile_done is one cycle", 32'(tile_done), 32'd0);

    load_tile(TA, 1'b1);
    stream_check(BA, -1, 0, "gaps");

    load_tile(TA, 1'b0);
    stream_check(BA, 3, 3, "hold");

    load_tile(TA, 1'b0);
    for (int b = 0; b < 3; b++) begin
      step();
      chk("pre-reset beat", out_data, BA[b]);
    end
    #2 reset = 1'b0;
    #1;
    chk("async reset out_data", out_data, 32'd0);
    chk("async reset out_valid", 32'(out_valid), 32'd0);
    chk("async reset in_ready", 32'(in_ready), 32'd1);
    chk("async reset busy", 32'(busy), 32'd0);
    step();
    step();
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("no tile_done after abort", 32'(tile_done), 32'd0);
      chk("no beats after abort", 32'(out_valid), 32'd0);
    end
    load_tile(TB, 1'b0);
    stream_check(BB, -1, 0, "after reset");

`ifdef FEEDER_PINGPONG_EN
    load_tile(TA, 1'b0);
    fork
      load_tile(TB, 1'b0);
      stream_check(BA, -1, 0, "b2b first");
    join
    stream_check(BB, -1, 0, "b2b second");
`else
    load_tile(TA, 1'b0);
    in_valid = 1'b1;
    in_data  = TB[0];
    stream_check(BA, -1, 0, "b2b first");
    load_tile(TB, 1'b0);
    stream_check(BB, -1, 0, "b2b second");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
